// File: rtl/tcm_dport_arb.sv
// Two-requester arbiter for the TCM data port with an in-order response ID FIFO.
// Ports: clk, rst (sync, active-low); m0_*/m1_* requester side; s_* downstream
// TCM side; protocol_err_o sticky flag for a response with nothing outstanding.
// Define TCM_DPORT_ARB_RR_EN for round-robin arbitration (default: m0 wins).
module tcm_dport_arb #(
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_wr_i,
  input  logic        m0_rd_i,
  input  logic [3:0]  m0_wr_i,
  input  logic [10:0] m0_req_tag_i,
  output logic        m0_accept_o,
  output logic        m0_ack_o,
  output logic        m0_error_o,
  output logic [31:0] m0_data_rd_o,
  output logic [10:0] m0_resp_tag_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_wr_i,
  input  logic        m1_rd_i,
  input  logic [3:0]  m1_wr_i,
  input  logic [10:0] m1_req_tag_i,
  output logic        m1_accept_o,
  output logic        m1_ack_o,
  output logic        m1_error_o,
  output logic [31:0] m1_data_rd_o,
  output logic [10:0] m1_resp_tag_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_wr_o,
  output logic        s_rd_o,
  output logic [3:0]  s_wr_o,
  output logic [10:0] s_req_tag_o,
  input  logic        s_accept_i,
  input  logic        s_ack_i,
  input  logic        s_error_i,
  input  logic [31:0] s_data_rd_i,
  input  logic [10:0] s_resp_tag_i,
  output logic        protocol_err_o
);

  localparam int PW = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t        state;
  logic          lock_id;
  logic          err_q;
  logic          fifo_q [OUTSTANDING_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

`ifdef TCM_DPORT_ARB_RR_EN
  logic          last_id;
`endif

  logic req0;
  logic req1;
  logic gnt;
  logic gnt_valid;
  logic full;
  logic empty;
  logic present;
  logic accept;
  logic pop;
  logic head;
  logic resp_ok;

  assign req0  = m0_rd_i | (|m0_wr_i);
  assign req1  = m1_rd_i | (|m1_wr_i);
  assign full  = (count == (PW+1)'(OUTSTANDING_DEPTH));
  assign empty = (count == '0);

  // A stalled request keeps the grant until the TCM takes it.
  always_comb begin
    gnt       = 1'b0;
    gnt_valid = 1'b0;
    if (state == LOCK) begin
      gnt       = lock_id;
      gnt_valid = lock_id ? req1 : req0;
    end else if (req0 && req1) begin
      gnt_valid = 1'b1;
`ifdef TCM_DPORT_ARB_RR_EN
      gnt       = ~last_id;
`else
      gnt       = 1'b0;
`endif
    end else if (req0 || req1) begin
      gnt_valid = 1'b1;
      gnt       = req1;
    end
  end

  assign present = rst & gnt_valid & ~full;
  assign accept  = present & s_accept_i;

  assign s_addr_o    = gnt ? m1_addr_i    : m0_addr_i;
  assign s_data_wr_o = gnt ? m1_data_wr_i : m0_data_wr_i;
  assign s_req_tag_o = gnt ? m1_req_tag_i : m0_req_tag_i;
  assign s_rd_o      = present & (gnt ? m1_rd_i : m0_rd_i);
  assign s_wr_o      = present ? (gnt ? m1_wr_i : m0_wr_i) : 4'b0;

  assign m0_accept_o = accept & ~gnt;
  assign m1_accept_o = accept & gnt;

  // Responses return in order; the FIFO head names their owner.
  assign head    = fifo_q[rd_ptr];
  assign resp_ok = rst & ~empty;
  assign pop     = resp_ok & s_ack_i;

  assign m0_ack_o      = pop & ~head;
  assign m1_ack_o      = pop & head;
  assign m0_error_o    = pop & ~head & s_error_i;
  assign m1_error_o    = pop & head & s_error_i;
  assign m0_data_rd_o  = (resp_ok & ~head) ? s_data_rd_i  : 32'b0;
  assign m1_data_rd_o  = (resp_ok & head)  ? s_data_rd_i  : 32'b0;
  assign m0_resp_tag_o = (resp_ok & ~head) ? s_resp_tag_i : 11'b0;
  assign m1_resp_tag_o = (resp_ok & head)  ? s_resp_tag_i : 11'b0;

  assign protocol_err_o = err_q & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      lock_id <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_q   <= 1'b0;
`ifdef TCM_DPORT_ARB_RR_EN
      last_id <= 1'b1;
`endif
    end else begin
      if (accept) begin
        fifo_q[wr_ptr] <= gnt;
        wr_ptr <= (wr_ptr == PW'(OUTSTANDING_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
`ifdef TCM_DPORT_ARB_RR_EN
        last_id <= gnt;
`endif
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(OUTSTANDING_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_ack_i && empty) begin
        err_q <= 1'b1;
      end
      if (present && !s_accept_i) begin
        state   <= LOCK;
        lock_id <= gnt;
      end else if (req0 || req1) begin
        state <= GRANT;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
